frame_result_ctrl: RTL and testbench

FRAME_RESULT_CTRL -- requirements
Module: frame_result_ctrl

---
 rtl/frame_result_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_frame_result_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_result_ctrl.sv
// Frame result controller: collects per-window classifier verdicts into a
// per-frame summary, reports sequence errors, and drives a person LED with a
// hold-off of HOLD_FR person-free frames before it turns off.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   o_valid    - classifier result beat valid
//   is_person  - classifier verdict for the beat
//   sw_id      - slide-window index of the beat
//   sum_valid  - frame summary available (held until sum_ready)
//   sum_ready  - consumer accepts summary
//   sum_cnt    - person windows in frame (saturating)
//   sum_first  - lowest window index with person (all ones if none)
//   sum_person - frame contained at least one person
//   led        - person indicator
//   seq_err    - one-cycle pulse on window sequence violation
//   ovf        - one-cycle pulse when an unconsumed summary was overwritten
module frame_result_ctrl #(
  parameter int unsigned SW_W    = 11,
  parameter int unsigned NUM_SW  = 1200,
  parameter int unsigned HOLD_FR = 8,
  parameter int unsigned CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             o_valid,
  input  logic             is_person,
  input  logic [SW_W-1:0]  sw_id,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CNT_W-1:0] sum_cnt,
  output logic [SW_W-1:0]  sum_first,
  output logic             sum_person,
  output logic             led,
  output logic             seq_err,
  output logic             ovf
);

  localparam int unsigned HOLD_W = $clog2(HOLD_FR + 1);
  localparam logic [SW_W-1:0]   LAST_ID  = SW_W'(NUM_SW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_VAL = HOLD_W'(HOLD_FR);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW_W-1:0]   first_q, first_d;
  logic [SW_W-1:0]   exp_q, exp_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              sum_valid_q, sum_valid_d;
  logic [CNT_W-1:0]  sum_cnt_q, sum_cnt_d;
  logic [SW_W-1:0]   sum_first_q, sum_first_d;
  logic              sum_person_q, sum_person_d;
  logic              led_q, led_d;
  logic              seq_err_q, seq_err_d;
  logic              ovf_q, ovf_d;

  logic              complete_c;
  logic [CNT_W-1:0]  acc_cnt_c;
  logic [SW_W-1:0]   acc_first_c;

  // Accumulated values if the current beat is accepted; a zero count doubles
  // as the "no hit yet" flag because the counter saturates instead of wrapping.
  always_comb begin
    acc_cnt_c   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(is_person);
    acc_first_c = (cnt_q == '0 && is_person) ? sw_id : first_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    exp_d        = exp_q;
    hold_d       = hold_q;
    sum_valid_d  = sum_valid_q & ~sum_ready;
    sum_cnt_d    = sum_cnt_q;
    sum_first_d  = sum_first_q;
    sum_person_d = sum_person_q;
    led_d        = led_q;
    seq_err_d    = 1'b0;
    ovf_d        = 1'b0;
    complete_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (o_valid && sw_id == '0) begin
          state_d = ACCUM;
          cnt_d   = CNT_W'(is_person);
          first_d = is_person ? '0 : '1;
          exp_d   = SW_W'(1);
        end
      end
      ACCUM: begin
        if (o_valid) begin
          if (sw_id == exp_q) begin
            if (sw_id == LAST_ID) begin
              complete_c = 1'b1;
              state_d    = IDLE;
              cnt_d      = '0;
              first_d    = '0;
              exp_d      = '0;
            end else begin
              cnt_d   = acc_cnt_c;
              first_d = acc_first_c;
              exp_d   = exp_q + SW_W'(1);
            end
          end else if (sw_id == '0) begin
            // Out-of-order restart: the new beat opens a fresh frame.
            seq_err_d = 1'b1;
            cnt_d     = CNT_W'(is_person);
            first_d   = is_person ? '0 : '1;
            exp_d     = SW_W'(1);
          end else begin
            seq_err_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
            first_d   = '0;
            exp_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Summary load and LED hold-off on frame completion.
    if (complete_c) begin
      sum_valid_d  = 1'b1;
      sum_cnt_d    = acc_cnt_c;
      sum_first_d  = acc_first_c;
      sum_person_d = (acc_cnt_c != '0);
      ovf_d        = sum_valid_q & ~sum_ready;
      if (acc_cnt_c != '0) begin
        led_d  = 1'b1;
        hold_d = HOLD_VAL;
      end else if (hold_q <= HOLD_W'(1)) begin
        led_d  = 1'b0;
        hold_d = '0;
      end else begin
        hold_d = hold_q - HOLD_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      first_q      <= '0;
      exp_q        <= '0;
      hold_q       <= '0;
      sum_valid_q  <= 1'b0;
      sum_cnt_q    <= '0;
      sum_first_q  <= '0;
      sum_person_q <= 1'b0;
      led_q        <= 1'b0;
      seq_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      exp_q        <= exp_d;
      hold_q       <= hold_d;
      sum_valid_q  <= sum_valid_d;
      sum_cnt_q    <= sum_cnt_d;
      sum_first_q  <= sum_first_d;
      sum_person_q <= sum_person_d;
      led_q        <= led_d;
      seq_err_q    <= seq_err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign sum_valid  = sum_valid_q;
  assign sum_cnt    = sum_cnt_q;
  assign sum_first  = sum_first_q;
  assign sum_person = sum_person_q;
  assign led        = led_q;
  assign seq_err    = seq_err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_frame_result_ctrl.sv
// Self-checking bench for frame_result_ctrl: directed scenarios followed by
// randomized beats, all compared against a frame-list reference model.
module tb_frame_result_ctrl;

  localparam int unsigned SW_W    = 3;
  localparam int unsigned NUM_SW  = 4;
  localparam int unsigned HOLD_FR = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int ALL_ONES = (1 << SW_W) - 1;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             o_valid;
  logic             is_person;
  logic [SW_W-1:0]  sw_id;
  logic             sum_ready;
  logic             sum_valid;
  logic [CNT_W-1:0] sum_cnt;
  logic [SW_W-1:0]  sum_first;
  logic             sum_person;
  logic             led;
  logic             seq_err;
  logic             ovf;

  frame_result_ctrl #(
    .SW_W(SW_W), .NUM_SW(NUM_SW), .HOLD_FR(HOLD_FR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .o_valid(o_valid), .is_person(is_person),
    .sw_id(sw_id), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_cnt(sum_cnt), .sum_first(sum_first), .sum_person(sum_person),
    .led(led), .seq_err(seq_err), .ovf(ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the current frame is simply the list of verdicts seen so far.
  bit in_frame;
  bit fq[$];
  bit m_sv, m_person, m_led, m_seq, m_ovf;
  int m_cnt, m_first, m_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sum_valid"},  32'(sum_valid),  32'(m_sv));
    chk({tag, ".sum_cnt"},    32'(sum_cnt),    32'(m_cnt));
    chk({tag, ".sum_first"},  32'(sum_first),  32'(m_first));
    chk({tag, ".sum_person"}, 32'(sum_person), 32'(m_person));
    chk({tag, ".led"},        32'(led),        32'(m_led));
    chk({tag, ".seq_err"},    32'(seq_err),    32'(m_seq));
    chk({tag, ".ovf"},        32'(ovf),        32'(m_ovf));
  endtask

  task automatic model_reset();
    in_frame = 0;
    fq.delete();
    m_sv = 0; m_person = 0; m_led = 0; m_seq = 0; m_ovf = 0;
    m_cnt = 0; m_first = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit v, input bit p, input int id, input bit rdy);
    bit sv_prev = m_sv;
    bit complete = 0;
    int s = 0;
    int f = ALL_ONES;
    bit found = 0;
    m_seq = 0;
    if (v) begin
      if (!in_frame) begin
        if (id == 0) begin fq.delete(); fq.push_back(p); in_frame = 1; end
      end else if (id == fq.size()) begin
        fq.push_back(p);
        if (id == NUM_SW - 1) begin complete = 1; in_frame = 0; end
      end else if (id == 0) begin
        m_seq = 1; fq.delete(); fq.push_back(p);
      end else begin
        m_seq = 1; in_frame = 0; fq.delete();
      end
    end
    m_ovf = complete && sv_prev && !rdy;
    if (complete) begin
      foreach (fq[i]) begin
        s += int'(fq[i]);
        if (fq[i] && !found) begin f = i; found = 1; end
      end
      m_sv = 1;
      m_cnt = (s > CNT_SAT) ? CNT_SAT : s;
      m_first = f;
      m_person = (s != 0);
      if (s != 0) begin m_led = 1; m_hold = HOLD_FR; end
      else if (m_hold <= 1) begin m_led = 0; m_hold = 0; end
      else m_hold--;
      fq.delete();
    end else if (sv_prev && rdy) begin
      m_sv = 0;
    end
  endtask

  task automatic beat(input bit v, input bit p, input int id, input bit rdy, input string tag);
    @(negedge clk);
    o_valid = v; is_person = p; sw_id = SW_W'(id); sum_ready = rdy;
    model_step(v, p, id, rdy);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // One in-order frame; pers[i] is the verdict of window i.
  task automatic frame(input bit [3:0] pers, input bit rdy, input string tag);
    for (int i = 0; i < NUM_SW; i++) beat(1'b1, pers[i], i, rdy, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    o_valid = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; o_valid = 1'b0; is_person = 1'b0; sw_id = '0; sum_ready = 1'b0;
    model_reset();
    #3;
    do_reset("reset");

    // Basic frame 0,1,0,1
    frame(4'b1010, 1'b0, "f0101");
    chk("r034.cnt",    32'(sum_cnt),    32'd2);
    chk("r034.first",  32'(sum_first),  32'd1);
    chk("r034.person", 32'(sum_person), 32'd1);
    chk("r034.led",    32'(led),        32'd1);
    chk("r034.valid",  32'(sum_valid),  32'd1);

    // Sequence gap 0,1,3 (summary consumed on the first beat)
    beat(1, 0, 0, 1, "gap0");
    beat(1, 0, 1, 0, "gap1");
    beat(1, 0, 3, 0, "gap3");
    chk("r035.seq_err", 32'(seq_err),   32'd1);
    chk("r035.valid",   32'(sum_valid), 32'd0);
    chk("r035.led",     32'(led),       32'd1);
    beat(0, 0, 0, 0, "gap_idle");
    beat(1, 1, 2, 0, "idle_drop");
    chk("idle_drop.seq_err", 32'(seq_err), 32'd0);

    // Overwrite of unconsumed summary
    frame(4'b0001, 1'b0, "ovf_a");
    frame(4'b0110, 1'b0, "ovf_b");
    chk("r036.ovf",   32'(ovf),       32'd1);
    chk("r036.cnt",   32'(sum_cnt),   32'd2);
    chk("r036.first", 32'(sum_first), 32'd1);
    beat(0, 0, 0, 1, "ack");
    chk("ack.valid", 32'(sum_valid), 32'd0);

    // LED hold-off, summaries consumed in the completion cycle
    frame(4'b1000, 1'b1, "led_p");
    chk("r037.led1", 32'(led), 32'd1);
    frame(4'b0000, 1'b1, "led_e1");
    chk("r037.led2", 32'(led), 32'd1);
    chk("r037.first_none", 32'(sum_first), 32'(ALL_ONES));
    frame(4'b0000, 1'b1, "led_e2");
    chk("r037.led3", 32'(led), 32'd0);

    // Restart at id 0 and out-of-range id
    beat(1, 1, 0, 1, "rs0");
    beat(1, 1, 1, 1, "rs1");
    beat(1, 0, 0, 1, "rs_again");
    chk("restart.seq_err", 32'(seq_err), 32'd1);
    beat(1, 0, 1, 1, "rs_b1");
    beat(1, 1, 2, 1, "rs_b2");
    beat(1, 0, 3, 1, "rs_b3");
    chk("restart.cnt", 32'(sum_cnt), 32'd1);
    beat(1, 0, 0, 1, "oor0");
    beat(1, 0, 1, 1, "oor1");
    beat(1, 0, 6, 1, "oor6");
    chk("oor.seq_err", 32'(seq_err), 32'd1);

    // Reset mid-frame
    beat(1, 1, 0, 1, "pre0");
    beat(1, 1, 1, 1, "pre1");
    do_reset("reset_mid");
    beat(1, 1, 2, 0, "post_drop");
    frame(4'b0100, 1'b0, "post");
    chk("r038.cnt",   32'(sum_cnt),   32'd1);
    chk("r038.first", 32'(sum_first), 32'd2);

    // Saturation
    frame(4'b1111, 1'b1, "sat");
    chk("r039.cnt",   32'(sum_cnt),   32'(CNT_SAT));
    chk("r039.first", 32'(sum_first), 32'd0);

    // Randomized beats, mostly in order
    for (int n = 0; n < 600; n++) begin
      bit v = ($urandom_range(0, 3) != 0);
      bit p = ($urandom_range(0, 1) != 0);
      bit r = ($urandom_range(0, 2) == 0);
      int id = in_frame ? fq.size() : 0;
      if ($urandom_range(0, 9) > 7) id = $urandom_range(0, ALL_ONES);
      if (n == 300) do_reset("reset_rand");
      beat(v, p, id, r, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
